adc_receiver: RTL

ADC_RECEIVER -- requirements
Module: adc_receiver

---
 rtl/ising_config.sv | 29 ++
 rtl/config_reg.sv | 21 ++
 rtl/threshold_detector.sv | 28 ++
 rtl/adc_receiver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ising_config.sv
// Shared Ising-machine configuration: datapath widths, calibration FSM states,
// and the saturation helper used by the ADC receiver.
package ising_config;

    localparam int num_bits   = 8;
    localparam int sample_w   = 16;
    localparam int sample_cnt = 16;
    localparam int sel_w      = $clog2(sample_cnt);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } del_state_t;

    localparam logic signed [sample_w-1:0] sat_max = sample_w'((1 << (num_bits - 1)) - 1);
    localparam logic signed [sample_w-1:0] sat_min = sample_w'(-(1 << (num_bits - 1)));

    // Clamp a full-width sample into the signed num_bits output range.
    function automatic logic [num_bits-1:0] sat_sample(input logic signed [sample_w-1:0] v);
        if (v > sat_max)
            return sat_max[num_bits-1:0];
        else if (v < sat_min)
            return sat_min[num_bits-1:0];
        else
            return v[num_bits-1:0];
    endfunction

endpackage

// File: rtl/config_reg.sv
// One 8-bit GPIO-mapped configuration register; writes on an address match
// while the (already edge-qualified) write enable is high.
module config_reg #(
    parameter logic [15:0] addr = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (wr_en && (wr_addr == addr))
            q <= wr_data;
    end

endmodule

// File: rtl/threshold_detector.sv
// Per-lane signed compare against a threshold, plus a lowest-index priority
// encoder over the lanes that crossed.
module threshold_detector
    import ising_config::*;
(
    input  logic [sample_cnt-1:0][sample_w-1:0] samples,
    input  logic [sample_w-1:0]                 thresh,
    output logic                                hit,
    output logic [sel_w-1:0]                    idx
);

    logic [sample_cnt-1:0] gt;

    for (genvar i = 0; i < sample_cnt; i++) begin : g_lane
        assign gt[i] = $signed(samples[i]) > $signed(thresh);
    end

    // Scan high to low so the lowest crossing lane wins.
    always_comb begin
        hit = |gt;
        idx = '0;
        for (int i = sample_cnt - 1; i >= 0; i--) begin
            if (gt[i])
                idx = sel_w'(i);
        end
    end

endmodule

// File: rtl/adc_receiver.sv
// ADC receiver: GPIO-configured sample select / scale / saturate pipeline and
// an independent delay-calibration measurement FSM.
module adc_receiver
    import ising_config::*;
#(
    parameter logic [15:0] sample_sel_reg_addr = 16'd5,
    parameter logic [15:0] shift_amt_reg_addr  = 16'd6,
    parameter logic [15:0] thresh_lo_reg_addr  = 16'd7,
    parameter logic [15:0] thresh_hi_reg_addr  = 16'd8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    gpio_in,
    input  logic [sample_cnt*sample_w-1:0] adc_in,
    input  logic                           adc_valid,
    input  logic                           del_trig,
    output logic [num_bits-1:0]            fsm_val_out,
    output logic                           fsm_out_valid,
    output logic [7:0]                     del_cycles,
    output logic [sel_w-1:0]               del_sample,
    output logic                           del_done,
    output logic                           del_timeout
);

    localparam int STAGES = 2;

    logic [15:0] gpio_addr;
    logic [7:0]  gpio_data;
    logic        strobe_q;
    logic        wr_pulse;

    logic [7:0] sample_sel_q;
    logic [7:0] shift_amt_q;
    logic [7:0] thresh_lo_q;
    logic [7:0] thresh_hi_q;

    assign gpio_addr = gpio_in[15:0];
    assign gpio_data = gpio_in[23:16];
    assign wr_pulse  = gpio_in[24] & ~strobe_q;

    always_ff @(posedge clk) begin
        if (!rst)
            strobe_q <= 1'b0;
        else
            strobe_q <= gpio_in[24];
    end

    config_reg #(.addr(sample_sel_reg_addr)) u_sample_sel (
        .clk(clk), .rst(rst), .wr_en(wr_pulse), .wr_addr(gpio_addr), .wr_data(gpio_data), .q(sample_sel_q)
    );
    config_reg #(.addr(shift_amt_reg_addr)) u_shift_amt (
        .clk(clk), .rst(rst), .wr_en(wr_pulse), .wr_addr(gpio_addr), .wr_data(gpio_data), .q(shift_amt_q)
    );
    config_reg #(.addr(thresh_lo_reg_addr)) u_thresh_lo (
        .clk(clk), .rst(rst), .wr_en(wr_pulse), .wr_addr(gpio_addr), .wr_data(gpio_data), .q(thresh_lo_q)
    );
    config_reg #(.addr(thresh_hi_reg_addr)) u_thresh_hi (
        .clk(clk), .rst(rst), .wr_en(wr_pulse), .wr_addr(gpio_addr), .wr_data(gpio_data), .q(thresh_hi_q)
    );

    // ---------------- data path ----------------
    logic [sample_cnt-1:0][sample_w-1:0] samples;
    logic signed [sample_w-1:0]          s1_sample;
    logic signed [sample_w-1:0]          s1_shifted;
    logic [STAGES:0]                     vld_pipe;

    assign samples     = adc_in;
    assign vld_pipe[0] = adc_valid;
    assign s1_shifted  = s1_sample >>> shift_amt_q[3:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe[STAGES:1] <= '0;
            s1_sample          <= '0;
            fsm_val_out        <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0])
                s1_sample <= samples[sample_sel_q[sel_w-1:0]];
            // Output register only moves on a valid stage-1 word, else holds.
            if (vld_pipe[1])
                fsm_val_out <= sat_sample(s1_shifted);
        end
    end

    assign fsm_out_valid = vld_pipe[STAGES];

    // ---------------- delay calibration ----------------
    logic             det_hit;
    logic [sel_w-1:0] det_idx;

    threshold_detector u_det (
        .samples(samples),
        .thresh ({thresh_hi_q, thresh_lo_q}),
        .hit    (det_hit),
        .idx    (det_idx)
    );

    del_state_t       state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [7:0]       del_cycles_nxt;
    logic [sel_w-1:0] del_sample_nxt;
    logic             del_done_nxt;
    logic             del_timeout_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            del_cycles  <= '0;
            del_sample  <= '0;
            del_done    <= 1'b0;
            del_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            del_cycles  <= del_cycles_nxt;
            del_sample  <= del_sample_nxt;
            del_done    <= del_done_nxt;
            del_timeout <= del_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        del_cycles_nxt  = del_cycles;
        del_sample_nxt  = del_sample;
        del_done_nxt    = del_done;
        del_timeout_nxt = del_timeout;
        unique case (state)
            IDLE, DONE: begin
                if (del_trig) begin
                    state_nxt       = ARMED;
                    cnt_nxt         = '0;
                    del_done_nxt    = 1'b0;
                    del_timeout_nxt = 1'b0;
                end
            end
            ARMED: begin
                // A crossing at the final count beats the timeout.
                if (adc_valid && det_hit) begin
                    state_nxt      = DONE;
                    del_cycles_nxt = cnt;
                    del_sample_nxt = det_idx;
                    del_done_nxt   = 1'b1;
                end else if (cnt == 8'd255) begin
                    state_nxt       = DONE;
                    del_cycles_nxt  = 8'd255;
                    del_sample_nxt  = '0;
                    del_timeout_nxt = 1'b1;
                    del_done_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
